hilo_ctrl: RTL
==============

Name: hilo_ctrl

Overview:
- Downstream consumer of the mul/div datapath's 64-bit hilo result.
- Sequences MULT/DIV operations with a latency counter, latches the result into architectural HI/LO registers, and serves MTHI/MTLO/MFHI/MFLO.
- Raises a pipeline stall while a result is pending.
- Sits between decode/execute control and the register-file writeback mux.

Parameters:
- WIDTH, 32, data word width; HI/LO are WIDTH each, md_result is 2*WIDTH.
- MUL_LAT, 32, cycles from accepted multiply start to HI/LO update; must be >= 1.
- DIV_LAT, 33, cycles from accepted divide start to HI/LO update; must be >= 1.
- CNT_W, 6, latency counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch mul/div operation (valid in IDLE only).
- op_div  input  1  with start: 1 = divide (DIV_LAT), 0 = multiply (MUL_LAT).
- md_result  input  2*WIDTH  hilo output of mul/div datapath; [2W-1:W] -> HI, [W-1:0] -> LO.
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  data for mthi/mtlo.
- mfhi  input  1  read HI.
- mflo  input  1  read LO.
- rdata  output  WIDTH  read data, combinational.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.
- busy  output  1  operation in flight.
- stall  output  1  hold requesting instruction upstream.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, hi=0, lo=0. busy=0, stall=0, rdata=0. Reset mid-operation aborts; the pending result is discarded.
- States: IDLE, BUSY. busy = (state==BUSY).
- IDLE, start=1 (edge): cnt <= op_div ? DIV_LAT : MUL_LAT; state <= BUSY.
- BUSY, each edge: cnt <= cnt-1.
- BUSY, cnt==1 at an edge: hi <= md_result[2W-1:W]; lo <= md_result[W-1:0]; state <= IDLE.
- Timing: with start sampled at edge E0, HI/LO hold the new value after edge E0+LAT. busy is high for exactly LAT cycles.
- md_result is sampled only on the capture edge; the datapath must hold it valid there.
- stall = busy & (start | mthi | mtlo | mfhi | mflo), combinational.
- While BUSY, start/mthi/mtlo are ignored (no state change); upstream re-presents them after stall drops.
- IDLE, mthi / mtlo (edge): hi <= wdata / lo <= wdata. Both asserted: both written with wdata.
- IDLE, start together with mthi/mtlo: the write takes effect this edge, the operation launches, and the later result overwrites HI/LO.
- rdata = mfhi ? hi : (mflo ? lo : 0). mfhi has priority if both are set.
- rdata is presented even when stall=1, but is architecturally valid only when stall=0.
- Latency-1 case: capture occurs on the first BUSY edge; busy is high for one cycle.
- Counter never wraps: cnt is not decremented in IDLE and holds 0.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: in IDLE, rdata forwards same-cycle writes. mfhi with mthi returns wdata; mflo with mtlo returns wdata.
- Defined: in BUSY at cnt==1 with mfhi/mflo, stall is deasserted and rdata returns the matching half of md_result.
- Not defined: rdata always reflects the registered hi/lo. mf* during any BUSY cycle stalls, including the capture cycle.

Test Plan:
- Reset: rst=1 mid-BUSY (cnt=10) -> immediately state IDLE, hi=lo=0, busy=0; after release, a start is accepted.
- Multiply: start=1, op_div=0 at E0, md_result=64'h0000_0001_FFFF_FFFE held -> busy high 32 cycles; after E0+32, hi=32'h1, lo=32'hFFFF_FFFE.
- Divide stall: start with op_div=1, then mflo asserted each cycle -> stall=1 for 33 cycles (32 with HILO_BYPASS_EN); first unstalled read returns md_result[31:0].
- Ignored writes: mthi=1, wdata=32'hDEAD_BEEF during BUSY -> stall=1, hi unchanged. Same mthi in IDLE -> hi=32'hDEAD_BEEF next cycle.
- Simultaneous: IDLE, start+mtlo (wdata=32'h1234), MUL_LAT=1 for this run -> lo=32'h1234 after E0, then lo=md_result[31:0] after E0+1.
- Bypass (HILO_BYPASS_EN): IDLE, hi=0, mfhi+mthi with wdata=32'h55AA -> rdata=32'h55AA same cycle. Without the macro, rdata=0.

Source files
------------

// File: rtl/hilo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hilo_ctrl                                                      |
// | Desc    : HI/LO sequencing for mul/div results with MTHI/MTLO/MFHI/MFLO. |
// |           Optional macro HILO_BYPASS_EN forwards same-cycle writes and   |
// |           the capture-cycle result onto rdata.                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module hilo_ctrl #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 32,
   parameter int DIV_LAT = 33,
   parameter int CNT_W   = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 op_div,
   input  logic [2*WIDTH-1:0]   md_result,
   input  logic                 mthi,
   input  logic                 mtlo,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 mfhi,
   input  logic                 mflo,
   output logic [WIDTH-1:0]     rdata,
   output logic [WIDTH-1:0]     hi,
   output logic [WIDTH-1:0]     lo,
   output logic                 busy,
   output logic                 stall
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_busy;
   logic               w_capture;
   logic               w_req;
   logic [WIDTH-1:0]   w_md_hi;
   logic [WIDTH-1:0]   w_md_lo;

   assign w_busy    = (r_state == S_BUSY);
   assign w_capture = w_busy && (r_cnt == c_cnt_one);
   assign w_req     = start | mthi | mtlo | mfhi | mflo;
   assign w_md_hi   = md_result[2*WIDTH-1:WIDTH];
   assign w_md_lo   = md_result[WIDTH-1:0];

   // Writes and launches are only honoured in IDLE; while BUSY the
   // requester is stalled and re-presents them afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mthi) r_hi <= wdata;
               if (mtlo) r_lo <= wdata;
               if (start) begin
                  r_cnt   <= op_div ? c_div_cnt : c_mul_cnt;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - c_cnt_one;
               if (w_capture) begin
                  r_hi    <= w_md_hi;
                  r_lo    <= w_md_lo;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = w_busy;

`ifdef HILO_BYPASS_EN
   // A pure read on the capture cycle can be served from md_result directly.
   logic w_mf_release;
   assign w_mf_release = w_capture & (mfhi | mflo) & ~(start | mthi | mtlo);
   assign stall        = w_busy & w_req & ~w_mf_release;
`else
   assign stall        = w_busy & w_req;
`endif

   always_comb begin
      rdata = '0;
      if (mfhi)      rdata = r_hi;
      else if (mflo) rdata = r_lo;
`ifdef HILO_BYPASS_EN
      if (!w_busy) begin
         if (mfhi && mthi)               rdata = wdata;
         else if (!mfhi && mflo && mtlo) rdata = wdata;
      end else if (w_capture) begin
         if (mfhi)      rdata = w_md_hi;
         else if (mflo) rdata = w_md_lo;
      end
`endif
   end

endmodule
`default_nettype wire
